// File: rtl/sc_pair_sched.sv
// sc_pair_sched: job scheduler for two stochastic-computing bitstream
// generators that share one set of Sobol direction numbers. A job latches
// the operand pair, holds the generators cleared for one cycle, enables them,
// and counts coincident ones (an AND-based SC multiply) over LEN paired
// samples. The result leaves through a valid/ready port.
module sc_pair_sched #(
   parameter int W       = 6,
   parameter int LEN     = 64,
   parameter int M_WIDTH = 36
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               req_valid,
   output logic               req_ready,
   input  logic [W-1:0]       req_a,
   input  logic [W-1:0]       req_b,
   input  logic [M_WIDTH-1:0] req_m,

   input  logic               abort,

   output logic               gen_en,
   output logic [W-1:0]       gen_num_a,
   output logic [W-1:0]       gen_num_b,
   output logic [M_WIDTH-1:0] gen_m,
   input  logic               gen_valid_a,
   input  logic               gen_seq_a,
   input  logic               gen_valid_b,
   input  logic               gen_seq_b,

   output logic               res_valid,
   input  logic               res_ready,
   output logic [W:0]         res_count,
   output logic               res_aborted,
   output logic               res_err,

   output logic               busy
);

   // Index of the final paired sample. The counters are one bit wider than
   // the operands, so LEN = 2^W fits and the compare is exact, never modular.
   localparam logic [W:0] LAST_IDX = (W+1)'(LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t     state;
   state_t     state_next;

   logic [W:0] sample_cnt;
   logic [W:0] ones_cnt;
   logic       aborted_flag;
   logic       err_flag;

   logic       paired;
   logic       lone;
   logic       last_sample;
   logic       accept;

   // Sample classification: a pair needs both strobes together; a strobe
   // on only one side is a protocol error and is never counted.
   always_comb begin
      paired      = gen_valid_a & gen_valid_b;
      lone        = gen_valid_a ^ gen_valid_b;
      last_sample = paired && (sample_cnt == LAST_IDX);
      accept      = (state == S_IDLE) && req_valid;
   end

   // State register; reset returns straight to IDLE, which also drops gen_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status decode. LOAD is a single cycle with the
   // generators disabled so both restart from sequence index 0. A result
   // handshake always returns to IDLE first, so a request can never be
   // accepted in the same cycle the result is taken.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      busy       = 1'b1;
      gen_en     = 1'b0;
      res_valid  = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_next = S_DONE;
            end else begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            gen_en = 1'b1;
            if (abort || last_sample) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Operand capture: the latched operands and direction numbers stay put
   // from one accepted request until the next, independent of job progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         gen_num_a <= '0;
         gen_num_b <= '0;
         gen_m     <= '0;
      end else if (accept) begin
         gen_num_a <= req_a;
         gen_num_b <= req_b;
         gen_m     <= req_m;
      end
   end

   // Job counters and sticky flags. They are cleared on accept and only
   // move during RUN (or LOAD for abort), so they hold steady while DONE
   // waits for the consumer. A pair arriving with abort is still counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cnt   <= '0;
         ones_cnt     <= '0;
         aborted_flag <= 1'b0;
         err_flag     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  sample_cnt   <= '0;
                  ones_cnt     <= '0;
                  aborted_flag <= 1'b0;
                  err_flag     <= 1'b0;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  aborted_flag <= 1'b1;
               end
            end
            S_RUN: begin
               if (paired) begin
                  sample_cnt <= sample_cnt + 1'b1;
                  if (gen_seq_a && gen_seq_b) begin
                     ones_cnt <= ones_cnt + 1'b1;
                  end
               end
               if (lone) begin
                  err_flag <= 1'b1;
               end
               if (abort) begin
                  aborted_flag <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Result port mirrors the held job registers.
   always_comb begin
      res_count   = ones_cnt;
      res_aborted = aborted_flag;
      res_err     = err_flag;
   end

endmodule

// File: tb/tb_sc_pair_sched.sv
// tb_sc_pair_sched: directed bench for sc_pair_sched. The bench plays both
// generators itself, driving strobes and sequence bits cycle by cycle, and
// compares every observable against hand-derived values.
module tb_sc_pair_sched;

   localparam int W       = 6;
   localparam int LEN     = 64;
   localparam int M_WIDTH = 36;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [W-1:0]       req_a = '0;
   logic [W-1:0]       req_b = '0;
   logic [M_WIDTH-1:0] req_m = '0;
   logic               abort = 1'b0;
   logic               gen_en;
   logic [W-1:0]       gen_num_a;
   logic [W-1:0]       gen_num_b;
   logic [M_WIDTH-1:0] gen_m;
   logic               gen_valid_a = 1'b0;
   logic               gen_seq_a = 1'b0;
   logic               gen_valid_b = 1'b0;
   logic               gen_seq_b = 1'b0;
   logic               res_valid;
   logic               res_ready = 1'b0;
   logic [W:0]         res_count;
   logic               res_aborted;
   logic               res_err;
   logic               busy;

   int total = 0;
   int bad   = 0;

   sc_pair_sched #(.W(W), .LEN(LEN), .M_WIDTH(M_WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_m       (req_m),
      .abort       (abort),
      .gen_en      (gen_en),
      .gen_num_a   (gen_num_a),
      .gen_num_b   (gen_num_b),
      .gen_m       (gen_m),
      .gen_valid_a (gen_valid_a),
      .gen_seq_a   (gen_seq_a),
      .gen_valid_b (gen_valid_b),
      .gen_seq_b   (gen_seq_b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_count   (res_count),
      .res_aborted (res_aborted),
      .res_err     (res_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_strobe(input logic va, input logic sa, input logic vb, input logic sb);
      gen_valid_a = va;
      gen_seq_a   = sa;
      gen_valid_b = vb;
      gen_seq_b   = sb;
   endtask

   // Present a request for one edge; the DUT is in IDLE when this is called.
   task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [M_WIDTH-1:0] m);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_m     = m;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic take_result();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if ({gen_en, res_valid, res_aborted, res_err, busy} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: got %b want 00000", {gen_en, res_valid, res_aborted, res_err, busy});
      end
      total++;
      if ({res_count, gen_num_a, gen_num_b, gen_m} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_data: got count=%0d a=%0d b=%0d m=%h want all 0", res_count, gen_num_a, gen_num_b, gen_m);
      end
      rst = 1'b0;
      tick();
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_full_count();
      start_job(6'd37, 6'd12, 36'h987654321);
      total++;
      if ({gen_en, busy, req_ready} !== 3'b010) begin
         bad++;
         $display("[TB] FAIL full_load_state: got en/busy/ready=%b want 010", {gen_en, busy, req_ready});
      end
      total++;
      if ({gen_num_a, gen_num_b, gen_m} !== {6'd37, 6'd12, 36'h987654321}) begin
         bad++;
         $display("[TB] FAIL full_latch: got a=%0d b=%0d m=%h want a=37 b=12 m=987654321", gen_num_a, gen_num_b, gen_m);
      end
      tick();
      for (int i = 0; i < LEN; i++) begin
         total++;
         if (gen_en !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_gen_en run cycle %0d: got %b want 1", i, gen_en);
         end
         set_strobe(1'b1, 1'b1, 1'b1, 1'b1);
         tick();
      end
      set_strobe(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({res_valid, gen_en} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL full_done: got valid/en=%b want 10", {res_valid, gen_en});
      end
      total++;
      if ({res_count, res_aborted, res_err} !== {7'd64, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL full_result: got count=%0d ab=%b err=%b want 64 0 0", res_count, res_aborted, res_err);
      end
      take_result();
      total++;
      if ({req_ready, res_valid, busy} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL full_release: got ready/valid/busy=%b want 100", {req_ready, res_valid, busy});
      end
   endtask

   task automatic test_half_rate();
      start_job(6'd20, 6'd40, 36'h0000000AB);
      tick();
      for (int i = 0; i < 2 * LEN - 1; i++) begin
         if (i % 2 == 0) begin
            set_strobe(1'b1, 1'b1, 1'b1, ((i / 2) % 2) == 0);
         end else begin
            set_strobe(1'b0, 1'b0, 1'b0, 1'b0);
         end
         if (i == 2 * LEN - 2) begin
            total++;
            if (res_valid !== 1'b0) begin
               bad++;
               $display("[TB] FAIL half_early_valid: got %b want 0", res_valid);
            end
         end
         tick();
      end
      set_strobe(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({res_valid, res_count, res_err} !== {1'b1, 7'd32, 1'b0}) begin
         bad++;
         $display("[TB] FAIL half_result: got valid=%b count=%0d err=%b want 1 32 0", res_valid, res_count, res_err);
      end
      take_result();
   endtask

   task automatic test_abort();
      start_job(6'd5, 6'd6, 36'h111111111);
      tick();
      for (int i = 0; i < 10; i++) begin
         set_strobe(1'b1, 1'b1, 1'b1, 1'b1);
         tick();
      end
      set_strobe(1'b0, 1'b0, 1'b0, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if ({res_valid, gen_en} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL abort_done: got valid/en=%b want 10", {res_valid, gen_en});
      end
      total++;
      if ({res_count, res_aborted} !== {7'd10, 1'b1}) begin
         bad++;
         $display("[TB] FAIL abort_result: got count=%0d ab=%b want 10 1", res_count, res_aborted);
      end
   endtask

   task automatic test_back_pressure();
      req_valid = 1'b1;
      req_a     = 6'd33;
      req_b     = 6'd44;
      req_m     = 36'hABCDEF012;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({res_valid, res_aborted, req_ready, res_count, gen_num_a} !== {1'b1, 1'b1, 1'b0, 7'd10, 6'd5}) begin
            bad++;
            $display("[TB] FAIL bp_hold cycle %0d: got valid=%b ab=%b ready=%b count=%0d a=%0d want 1 1 0 10 5",
                     i, res_valid, res_aborted, req_ready, res_count, gen_num_a);
         end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      total++;
      if ({req_ready, res_valid, gen_num_a} !== {1'b1, 1'b0, 6'd5}) begin
         bad++;
         $display("[TB] FAIL bp_handshake: got ready=%b valid=%b a=%0d want 1 0 5", req_ready, res_valid, gen_num_a);
      end
      tick();
      req_valid = 1'b0;
      total++;
      if ({gen_num_a, gen_num_b, gen_m} !== {6'd33, 6'd44, 36'hABCDEF012}) begin
         bad++;
         $display("[TB] FAIL bp_new_latch: got a=%0d b=%0d m=%h want 33 44 abcdef012", gen_num_a, gen_num_b, gen_m);
      end
      total++;
      if ({busy, res_valid, res_count, res_aborted} !== {1'b1, 1'b0, 7'd0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL bp_cleared: got busy=%b valid=%b count=%0d ab=%b want 1 0 0 0", busy, res_valid, res_count, res_aborted);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if ({res_valid, res_aborted, res_count} !== {1'b1, 1'b1, 7'd0}) begin
         bad++;
         $display("[TB] FAIL bp_abort_load: got valid=%b ab=%b count=%0d want 1 1 0", res_valid, res_aborted, res_count);
      end
      take_result();
   endtask

   task automatic test_abort_with_sample();
      start_job(6'd1, 6'd2, 36'h000000003);
      tick();
      for (int i = 0; i < 5; i++) begin
         set_strobe(1'b1, 1'b1, 1'b1, 1'b1);
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      set_strobe(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({res_valid, res_aborted, res_count} !== {1'b1, 1'b1, 7'd6}) begin
         bad++;
         $display("[TB] FAIL abort_same_cycle: got valid=%b ab=%b count=%0d want 1 1 6", res_valid, res_aborted, res_count);
      end
      take_result();
   endtask

   task automatic test_lone_strobe();
      start_job(6'd9, 6'd10, 36'h123456789);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_strobe(1'b1, 1'b1, 1'b1, 1'b1);
         tick();
      end
      set_strobe(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < LEN - 3; i++) begin
         set_strobe(1'b1, 1'b1, 1'b1, 1'b1);
         if (i == LEN - 4) begin
            total++;
            if (res_valid !== 1'b0) begin
               bad++;
               $display("[TB] FAIL lone_early_valid: got %b want 0", res_valid);
            end
         end
         tick();
      end
      set_strobe(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({res_valid, res_count, res_err, res_aborted} !== {1'b1, 7'd64, 1'b1, 1'b0}) begin
         bad++;
         $display("[TB] FAIL lone_result: got valid=%b count=%0d err=%b ab=%b want 1 64 1 0", res_valid, res_count, res_err, res_aborted);
      end
      take_result();
      start_job(6'd9, 6'd10, 36'h123456789);
      total++;
      if (res_err !== 1'b0) begin
         bad++;
         $display("[TB] FAIL lone_err_cleared: got %b want 0", res_err);
      end
      set_strobe(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      set_strobe(1'b0, 1'b0, 1'b0, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      set_strobe(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      set_strobe(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({res_valid, res_err, res_count, res_aborted} !== {1'b1, 1'b0, 7'd0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL lone_outside_run: got valid=%b err=%b count=%0d ab=%b want 1 0 0 1", res_valid, res_err, res_count, res_aborted);
      end
      take_result();
   endtask

   task automatic test_reset_mid_run();
      start_job(6'd11, 6'd22, 36'h555555555);
      tick();
      for (int i = 0; i < 19; i++) begin
         set_strobe(1'b1, 1'b1, 1'b1, 1'b1);
         tick();
      end
      rst = 1'b1;
      tick();
      set_strobe(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({gen_en, busy, res_valid, res_aborted, res_err} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL midrst_flags: got %b want 00000", {gen_en, busy, res_valid, res_aborted, res_err});
      end
      total++;
      if ({res_count, gen_num_a, gen_num_b, gen_m} !== '0) begin
         bad++;
         $display("[TB] FAIL midrst_data: got count=%0d a=%0d b=%0d m=%h want all 0", res_count, gen_num_a, gen_num_b, gen_m);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({req_ready, res_valid, busy} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL midrst_idle cycle %0d: got ready/valid/busy=%b want 100", i, {req_ready, res_valid, busy});
         end
      end
   endtask

   // Main sequence: each scenario leaves the DUT idle for the next one.
   initial begin
      test_reset();
      test_full_count();
      test_half_rate();
      test_abort();
      test_back_pressure();
      test_abort_with_sample();
      test_lone_strobe();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
